// File: rtl/weight_update_out_if.sv
// Memory-side bus shared by the hidden-activation and weight memories:
// one address, a common read strobe, two read ports and a weight write port.
interface weight_update_out_if;
  logic [7:0] addr;
  logic       rd_en;
  logic [7:0] h_rdata;
  logic [7:0] w_rdata;
  logic [7:0] w_wdata;
  logic       w_we;

  modport master (
    output addr, rd_en, w_wdata, w_we,
    input  h_rdata, w_rdata
  );

  modport slave (
    input  addr, rd_en, w_wdata, w_we,
    output h_rdata, w_rdata
  );
endinterface

// File: rtl/weight_update_out.sv
// Hidden-to-output weight update: w[i] <= sat8(w[i] + (delta*h[i]) >>> (8+LR_SHIFT))
// for i = 0..N_HID-1, three cycles per weight (FETCH, CALC, WRITE).
module weight_update_out #(
  parameter int N_HID    = 8,
  parameter int LR_SHIFT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [15:0]  delta,
  output logic                busy,
  output logic                done,
  output logic [7:0]          sat_cnt,
  weight_update_out_if.master mem
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_HID - 1);

  state_t             state, state_nxt;
  logic [7:0]         idx;
  logic signed [15:0] d_reg;
  logic signed [7:0]  res_reg;
  logic               sat_reg;

  logic signed [23:0] d_ext, h_ext, w_ext;
  logic signed [23:0] prod, dw, sum;
  logic signed [7:0]  sat_val;
  logic               sat_flag;

  // Multiply-shift-add datapath; h_rdata/w_rdata are valid during CALC.
  always_comb begin
    d_ext = {{8{d_reg[15]}}, d_reg};
    h_ext = {{16{mem.h_rdata[7]}}, mem.h_rdata};
    w_ext = {{16{mem.w_rdata[7]}}, mem.w_rdata};
    prod  = d_ext * h_ext;
    dw    = prod >>> (8 + LR_SHIFT);
    sum   = w_ext + dw;
    if (sum > 24'sd127) begin
      sat_val  = 8'sd127;
      sat_flag = 1'b1;
    end else if (sum < -24'sd128) begin
      sat_val  = -8'sd128;
      sat_flag = 1'b1;
    end else begin
      sat_val  = sum[7:0];
      sat_flag = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b1;
    done        = 1'b0;
    mem.addr    = 8'd0;
    mem.rd_en   = 1'b0;
    mem.w_we    = 1'b0;
    mem.w_wdata = 8'd0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        mem.rd_en = 1'b1;
        mem.addr  = idx;
        state_nxt = CALC;
      end
      CALC: state_nxt = WRITE;
      WRITE: begin
        mem.w_we    = 1'b1;
        mem.addr    = idx;
        mem.w_wdata = res_reg;
        state_nxt   = (idx == LAST_IDX) ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pass bookkeeping: delta capture, index, registered result, saturation count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= 8'd0;
      d_reg   <= 16'sd0;
      res_reg <= 8'sd0;
      sat_reg <= 1'b0;
      sat_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_reg   <= delta;
            idx     <= 8'd0;
            sat_cnt <= 8'd0;
          end
        end
        CALC: begin
          res_reg <= sat_val;
          sat_reg <= sat_flag;
        end
        WRITE: begin
          if (sat_reg && sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 8'd1;
          if (idx != LAST_IDX) idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update_out.sv
// Scoreboard bench for weight_update_out with N_HID=4, LR_SHIFT=4: expected
// writes are queued by the stimulus thread and checked by a write monitor.
module tb_weight_update_out;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [15:0] delta;
  logic               busy, done;
  logic [7:0]         sat_cnt;

  weight_update_out_if bus();

  weight_update_out #(.N_HID(N), .LR_SHIFT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .delta   (delta),
    .busy    (busy),
    .done    (done),
    .sat_cnt (sat_cnt),
    .mem     (bus)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, write on w_we, bulk load from the bench.
  logic [7:0] h_mem [N];
  logic [7:0] w_mem [N];
  logic [7:0] load_h [N];
  logic [7:0] load_w [N];
  logic       load_en;

  always @(posedge clk) begin
    if (load_en) begin
      h_mem <= load_h;
      w_mem <= load_w;
    end else if (bus.w_we) begin
      w_mem[bus.addr[1:0]] <= bus.w_wdata;
    end
    if (bus.rd_en) begin
      bus.h_rdata <= h_mem[bus.addr[1:0]];
      bus.w_rdata <= w_mem[bus.addr[1:0]];
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every DUT write must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.w_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h with nothing expected at %0t",
                   bus.addr, bus.w_wdata, $time);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", bus.addr, e.addr);
          check("wr_data", bus.w_wdata, e.data);
        end
      end
    end
  end

  task automatic load(input logic [7:0] h0, h1, h2, h3, w0, w1, w2, w3);
    load_h[0] = h0; load_h[1] = h1; load_h[2] = h2; load_h[3] = h3;
    load_w[0] = w0; load_w[1] = w1; load_w[2] = w2; load_w[3] = w3;
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] e0, e1, e2, e3, input int cnt);
    logic [7:0] v [N];
    v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
    for (int i = 0; i < cnt; i++) exp_q.push_back('{addr: 8'(i), data: v[i]});
  endtask

  // mode 0: pulse start; 1: re-pulse start with a new delta mid-pass;
  // 2: leave start high on return. sync=0 means the caller is already at a
  // negedge and start is taken at the very next rising edge.
  task automatic run_pass(input string name, input logic [15:0] d, input int mode,
                          input bit sync, input logic [7:0] exp_sat);
    bit seen = 1'b0;
    int cyc  = 0;
    if (sync) @(negedge clk);
    delta = d;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      cyc = i;
      if (i == 1) begin
        if (mode != 2) start = 1'b0;
        check({name, "_fetch0_busy"}, busy, 1);
        check({name, "_fetch0_rd"}, bus.rd_en, 1);
        check({name, "_fetch0_addr"}, bus.addr, 0);
      end
      if (mode == 1 && i == 5) begin
        start = 1'b1;
        delta = 16'h7FFF;
      end
      if (mode == 1 && i == 6) start = 1'b0;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no done within 200 cycles", name);
    end else begin
      check({name, "_done_cycle"}, cyc, 3 * N + 1);
    end
    check({name, "_sat_cnt"}, sat_cnt, exp_sat);
    check({name, "_writes_left"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    delta   = 16'h0000;
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_w_we", bus.w_we, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wdata", bus.w_wdata, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;

    // Basic pass: 10 + (256*64)>>>12 = 14 everywhere
    load(8'h40, 8'h40, 8'h40, 8'h40, 8'd10, 8'd10, 8'd10, 8'd10);
    push_exp(8'd14, 8'd14, 8'd14, 8'd14, 4);
    run_pass("basic", 16'h0100, 0, 1, 8'd0);

    // Positive saturation: dw=1015 for h=127; 32767>>>12=7 for h=1
    load(8'h7F, 8'h7F, 8'h00, 8'h01, 8'h78, 8'h80, 8'h32, 8'h00);
    push_exp(8'h7F, 8'h7F, 8'h32, 8'h07, 4);
    run_pass("possat", 16'h7FFF, 0, 1, 8'd2);
    repeat (3) @(negedge clk);
    check("sat_cnt_hold", sat_cnt, 2);
    check("idle_addr", bus.addr, 0);

    // Negative delta: -126-4 -> -128 sat, 0-4, 100+8, 127-8 (floor of -7.94)
    load(8'h40, 8'h40, 8'h80, 8'h7F, 8'h82, 8'h00, 8'h64, 8'h7F);
    push_exp(8'h80, 8'hFC, 8'h6C, 8'h77, 4);
    run_pass("negsat", 16'hFF00, 0, 1, 8'd1);

    // Floor rounding: -1>>>12 = -1
    load(8'h01, 8'h01, 8'h80, 8'h7F, 8'h05, 8'h80, 8'h00, 8'h80);
    push_exp(8'h04, 8'h80, 8'h00, 8'h80, 4);
    run_pass("floor", 16'hFFFF, 0, 1, 8'd2);

    // Start re-pulsed with a new delta mid-pass must change nothing
    load(8'h40, 8'h40, 8'h40, 8'h40, 8'd10, 8'd10, 8'd10, 8'd10);
    push_exp(8'd14, 8'd14, 8'd14, 8'd14, 4);
    run_pass("repulse", 16'h0100, 1, 1, 8'd0);
    @(negedge clk);
    check("repulse_no_restart", busy, 0);

    // Start held: one IDLE cycle, then a second pass on the updated weights
    load(8'h40, 8'h40, 8'h40, 8'h40, 8'd10, 8'd10, 8'd10, 8'd10);
    push_exp(8'd14, 8'd14, 8'd14, 8'd14, 4);
    run_pass("hold1", 16'h0100, 2, 1, 8'd0);
    @(negedge clk);
    check("hold_idle_gap", busy, 0);
    push_exp(8'd18, 8'd18, 8'd18, 8'd18, 4);
    run_pass("hold2", 16'h0100, 0, 0, 8'd0);

    // Reset in CALC of idx 2: only addr 0 and 1 are written
    load(8'h40, 8'h40, 8'h40, 8'h40, 8'd10, 8'd10, 8'd10, 8'd10);
    push_exp(8'd14, 8'd14, 8'd14, 8'd14, 2);
    @(negedge clk);
    delta = 16'h0100;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    check("calc2_busy", busy, 1);
    check("calc2_we", bus.w_we, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rd_en", bus.rd_en, 0);
    check("midrst_w_we", bus.w_we, 0);
    check("midrst_addr", bus.addr, 0);
    check("midrst_wdata", bus.w_wdata, 0);
    check("midrst_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_queue", exp_q.size(), 0);
    check("midrst_w1", w_mem[1], 14);
    check("midrst_w2", w_mem[2], 10);
    push_exp(8'd18, 8'd18, 8'd14, 8'd14, 4);
    run_pass("after_rst", 16'h0100, 0, 1, 8'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_update_out.md
WEIGHT_UPDATE_OUT -- requirements
Module: weight_update_out

Interface
REQ-001 SHALL have parameter N_HID, default 8, meaning the number of hidden-to-output weights updated per pass (2..256).
REQ-002 SHALL have parameter LR_SHIFT, default 4, meaning the learning-rate right shift applied on top of the fixed 8-bit product scaling.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port start  in  1  meaning a request to run one update pass, sampled only in IDLE.
REQ-006 SHALL have port delta  in  16  meaning the signed output-error term (ph_out of the loss stage), captured on accepted start.
REQ-007 SHALL have port addr  out  8  meaning the shared index into the hidden-activation and weight memories.
REQ-008 SHALL have port rd_en  out  1  meaning the read strobe to both memories; data returns 1 cycle later.
REQ-009 SHALL have port h_rdata  in  8  meaning the signed hidden activation at addr.
REQ-010 SHALL have port w_rdata  in  8  meaning the signed current weight at addr.
REQ-011 SHALL have port w_wdata  out  8  meaning the signed updated weight.
REQ-012 SHALL have port w_we  out  1  meaning the weight write strobe, asserted for one cycle per weight.
REQ-013 SHALL have port busy  out  1  meaning high in every state except IDLE.
REQ-014 SHALL have port done  out  1  meaning a one-cycle pulse at the end of a pass.
REQ-015 SHALL have port sat_cnt  out  8  meaning the count of saturated writes in the last pass, saturating at 255.

Function
REQ-016 SHALL implement the states IDLE, FETCH, CALC, WRITE and DONE.
REQ-017 SHALL move from IDLE to FETCH, latching delta into d_reg, clearing idx and clearing sat_cnt, when start=1; otherwise it SHALL stay in IDLE.
REQ-018 SHALL, in FETCH, drive rd_en=1 and addr=idx, then go to CALC.
REQ-019 SHALL, in CALC, form the signed 24-bit product prod = d_reg * h_rdata.
REQ-020 SHALL compute dw = prod >>> (8+LR_SHIFT) as an arithmetic shift with floor rounding, so -1 >>> n = -1.
REQ-021 SHALL compute sum = w_rdata + dw at 24-bit width and saturate it to [-128, 127].
REQ-022 SHALL register the saturated result and a sat flag in CALC, then go to WRITE.
REQ-023 SHALL, in WRITE, drive w_we=1, addr=idx and w_wdata=the registered result.
REQ-024 SHALL increment sat_cnt in WRITE if the sat flag is set and sat_cnt<255.
REQ-025 SHALL, in WRITE, go to DONE if idx=N_HID-1; otherwise it SHALL increment idx and go to FETCH.
REQ-026 SHALL drive done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-027 SHALL give latency: start accepted at edge k gives FETCH in cycle k+1 and the done pulse in cycle k+1+3*N_HID.
REQ-028 SHALL ignore start while busy=1; delta changes during a pass SHALL have no effect.
REQ-029 SHALL honour start asserted in the DONE cycle only after IDLE is reached; start held continuously SHALL restart a pass on the cycle after IDLE.
REQ-030 SHALL hold addr=0, w_wdata=0, rd_en=0 and w_we=0 outside FETCH and WRITE.
REQ-031 SHALL keep sat_cnt stable from DONE until the next accepted start.

Reset
REQ-032 SHALL, when rst_n=0 at a clock edge, force state=IDLE, idx=0, d_reg=0, sat_cnt=0, busy=0, done=0, rd_en=0, w_we=0, addr=0 and w_wdata=0.
REQ-033 SHALL, on reset mid-pass, issue no further write on or after the reset edge; weights already written remain as written.

Verification
REQ-034 SHALL cover: N_HID=4, LR_SHIFT=4, delta=0x0100, all h=0x40, all w=10, start pulse -> four writes of 14 at addr 0..3, done at cycle k+13, sat_cnt=0.
REQ-035 SHALL cover: delta=0x7FFF, h=0x7F, w=120 -> dw=1015, write 127, sat_cnt increments.
REQ-036 SHALL cover: delta=0xFF00, h=0x40, w=-126 -> dw=-4, write -128 (saturated); delta=0xFFFF, h=0x01, w=5 -> write 4 (floor).
REQ-037 SHALL cover: start re-pulsed and delta changed mid-pass -> no restart and results unchanged; start held high -> back-to-back passes with one IDLE cycle between done and the next FETCH.
REQ-038 SHALL cover: rst_n=0 during CALC of idx=2 -> no write to addr 2, all outputs at reset values next cycle, and a new start runs a full pass from addr 0.
